// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered N-channel, W-bit multiplexer with a valid/ready
// output stage and an auto-scan mode that walks the channels with a fixed
// dwell per channel.
// Optional feature macro: MUX_SCAN_MASK_EN adds the EN_MASK per-channel
// enable; without it every channel is treated as enabled.
//
// state   | meaning
// ST_MAN  | manual select: every accepted edge loads channel S
// ST_SCAN | auto-scan: dwell counter runs, one channel sampled per dwell
//
// The first edge after reset release only loads the state from MODE; no
// sample is taken on that edge (r_init marks it).
module mux_nx1_seq #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int DWELL    = 1,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS*WIDTH-1:0] I,
   input  logic [SEL_W-1:0]          S,
   input  logic                      MODE,
`ifdef MUX_SCAN_MASK_EN
   input  logic [CHANNELS-1:0]       EN_MASK,
`endif
   input  logic                      OUT_READY,
   output logic [WIDTH-1:0]          OUT,
   output logic [SEL_W-1:0]          OUT_CH,
   output logic                      OUT_VALID
);

   typedef enum logic {ST_MAN = 1'b0, ST_SCAN = 1'b1} state_t;

   localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_init;
   logic [WIDTH-1:0]   r_out, w_out_nxt;
   logic [SEL_W-1:0]   r_out_ch, w_out_ch_nxt;
   logic               r_out_valid, w_out_valid_nxt;
   logic [SEL_W-1:0]   r_ch, w_ch_nxt;
   logic [15:0]        r_dwell, w_dwell_nxt;

   logic [CHANNELS-1:0] w_en;
   logic                w_any_en;
   logic                w_acc;
   logic                w_s_ok;
   logic [SEL_W-1:0]    w_cur;
   logic [SEL_W-1:0]    w_next;
   logic [WIDTH-1:0]    w_chan [CHANNELS];

`ifdef MUX_SCAN_MASK_EN
   assign w_en = EN_MASK;
`else
   assign w_en = '1;
`endif

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      assign w_chan[k] = I[k*WIDTH +: WIDTH];
   end

   assign w_any_en = |w_en;
   assign w_acc    = !r_out_valid || OUT_READY;
   // S can exceed CHANNELS-1 when CHANNELS is not a power of two.
   assign w_s_ok   = (int'(S) < CHANNELS) && w_en[S];

   // Channel to sample (first enabled at or after r_ch) and the one after it.
   // Descending loops let the nearest enabled channel win.
   always_comb begin
      w_cur  = r_ch;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (w_en[SEL_W'((int'(r_ch) + i) % CHANNELS)])
            w_cur = SEL_W'((int'(r_ch) + i) % CHANNELS);
      end
      w_next = w_cur;
      for (int i = CHANNELS; i >= 1; i--) begin
         if (w_en[SEL_W'((int'(w_cur) + i) % CHANNELS)])
            w_next = SEL_W'((int'(w_cur) + i) % CHANNELS);
      end
   end

   // Next-state and datapath decisions; everything holds unless an accept
   // edge or a dwell step says otherwise.
   always_comb begin
      w_state_nxt     = MODE ? ST_SCAN : ST_MAN;
      w_out_nxt       = r_out;
      w_out_ch_nxt    = r_out_ch;
      w_out_valid_nxt = r_out_valid;
      w_ch_nxt        = r_ch;
      w_dwell_nxt     = r_dwell;
      if (r_init) begin
         case (r_state)
            ST_MAN: begin
               if (w_acc) begin
                  if (w_s_ok) begin
                     w_out_nxt       = w_chan[S];
                     w_out_ch_nxt    = S;
                     w_out_valid_nxt = 1'b1;
                  end else begin
                     w_out_valid_nxt = 1'b0;
                  end
               end
               // Scan always restarts from channel 0 with a fresh dwell.
               w_ch_nxt    = '0;
               w_dwell_nxt = '0;
            end
            ST_SCAN: begin
               if (r_dwell != DWELL_LAST) begin
                  w_dwell_nxt = r_dwell + 16'd1;
                  if (w_acc) w_out_valid_nxt = 1'b0;
               end else if (w_acc) begin
                  w_dwell_nxt = '0;
                  if (w_any_en) begin
                     w_out_nxt       = w_chan[w_cur];
                     w_out_ch_nxt    = w_cur;
                     w_out_valid_nxt = 1'b1;
                     w_ch_nxt        = w_next;
                  end else begin
                     w_out_valid_nxt = 1'b0;
                  end
               end
            end
            default: w_state_nxt = ST_MAN;
         endcase
      end
   end

   // State register: tracks MODE one edge late.
   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_MAN;
      else     r_state <= w_state_nxt;
   end

   // Output stage, scan pointer and dwell counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_init      <= 1'b0;
         r_out       <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_ch        <= '0;
         r_dwell     <= '0;
      end else begin
         r_init      <= 1'b1;
         r_out       <= w_out_nxt;
         r_out_ch    <= w_out_ch_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_ch        <= w_ch_nxt;
         r_dwell     <= w_dwell_nxt;
      end
   end

   assign OUT       = r_out;
   assign OUT_CH    = r_out_ch;
   assign OUT_VALID = r_out_valid;

endmodule
